// File: rtl/apb_master_arbiter_if.sv
// Requester command/response and APB bus bundle for apb_master_arbiter.
// The master modport is the arbiter side; slave is the environment side.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32
);
  localparam int SW = DATA_W / 8;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*SW-1:0]     req_strb;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;

  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [SW-1:0]             psrtb;
  logic [DATA_W-1:0]         pwdata;
  logic                      pready;
  logic                      pslverr;
  logic [DATA_W-1:0]         prdata;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_strb, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata,
    output rsp_err, rsp_timeout,
    output psel, penable, pwrite,
    output paddr, psrtb, pwdata,
    input  pready, pslverr, prdata
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_strb, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata,
    input  rsp_err, rsp_timeout,
    input  psel, penable, pwrite,
    input  paddr, psrtb, pwdata,
    output pready, pslverr, prdata
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ
// requesters, with bounded pready wait and per-requester responses.
module apb_master_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic reset,
  apb_master_arbiter_if.master bus
);
  localparam int SW = DATA_W / 8;
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [GW-1:0] G_RST = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [SW-1:0]     strb;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  state_t state, state_nxt;

  logic [GW-1:0]      last_grant;
  logic [GW-1:0]      win;
  logic [GW-1:0]      cand;
  logic               any_req;
  logic               accept;
  logic               done;
  logic               abort;
  logic               to_hit;
  logic               wr_sel;
  logic [NUM_REQ-1:0] grant_oh;
  logic [CW-1:0]      cnt;
  cmd_t               cmd_in;
  cmd_t               cmd_q;

  logic               psel_q;
  logic               penable_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic               to_q;

  // Later offsets are overwritten by earlier ones: first hit after last_grant wins.
  always_comb begin
    win     = last_grant;
    any_req = 1'b0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = GW'((int'(last_grant) + i) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    wr_sel       = bus.req_write[win];
    cmd_in.write = wr_sel;
    cmd_in.addr  = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
    cmd_in.strb  = '0;
    cmd_in.wdata = '0;
    if (wr_sel) begin
      cmd_in.strb  = bus.req_strb[int'(win)*SW +: SW];
      cmd_in.wdata = bus.req_wdata[int'(win)*DATA_W +: DATA_W];
    end
  end

  assign to_hit = (TIMEOUT != 0) && (cnt == CW'(TO_LAST));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_oh  = '0;
    accept    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          accept        = 1'b1;
          grant_oh[win] = 1'b1;
          state_nxt     = SETUP;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (to_hit) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant  <= G_RST;
      cmd_q       <= '0;
      cnt         <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      if (accept) begin
        last_grant <= win;
        cmd_q      <= cmd_in;
        psel_q     <= 1'b1;
        penable_q  <= 1'b0;
      end
      if (state == SETUP) begin
        penable_q <= 1'b1;
        cnt       <= '0;
      end else if (state == ACCESS && !done && TIMEOUT != 0) begin
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        psel_q                  <= 1'b0;
        penable_q               <= 1'b0;
        rsp_valid_q[last_grant] <= 1'b1;
        rdata_q <= cmd_q.write ? '0 : bus.prdata;
        err_q                   <= bus.pslverr;
        to_q                    <= 1'b0;
      end
      if (abort) begin
        psel_q                  <= 1'b0;
        penable_q               <= 1'b0;
        rsp_valid_q[last_grant] <= 1'b1;
        rdata_q                 <= '0;
        err_q                   <= 1'b1;
        to_q                    <= 1'b1;
      end
    end
  end

  assign bus.req_ready   = grant_oh;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_err     = err_q;
  assign bus.rsp_timeout = to_q;
  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = cmd_q.write;
  assign bus.paddr       = cmd_q.addr;
  assign bus.psrtb       = cmd_q.strb;
  assign bus.pwdata      = cmd_q.wdata;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed plus random stimulus for apb_master_arbiter, checked
// against a transaction-level round-robin model.
module tb_apb_master_arbiter;
  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  apb_master_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_last;

  logic [N-1:0]  vmask;
  logic          wr_a[N];
  logic [AW-1:0] ad_a[N];
  logic [SW-1:0] st_a[N];
  logic [DW-1:0] wd_a[N];

  logic [DW-1:0] exp_rdata;
  logic          exp_err;
  logic          exp_to;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    logic [N*AW-1:0] pa;
    logic [N*SW-1:0] ps;
    logic [N*DW-1:0] pd;
    logic [N-1:0]    pw;
    for (int i = 0; i < N; i++) begin
      pa[i*AW +: AW] = ad_a[i];
      ps[i*SW +: SW] = st_a[i];
      pd[i*DW +: DW] = wd_a[i];
      pw[i]          = wr_a[i];
    end
    bus.req_valid = vmask;
    bus.req_write = pw;
    bus.req_addr  = pa;
    bus.req_strb  = ps;
    bus.req_wdata = pd;
  endtask

  function automatic int rr_pick(input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(exp_last + k) % N]) return (exp_last + k) % N;
    end
    return -1;
  endfunction

  task automatic set_cmd(input int i, input logic w, input logic [AW-1:0] a,
                         input logic [SW-1:0] s, input logic [DW-1:0] d);
    vmask[i] = 1'b1;
    wr_a[i]  = w;
    ad_a[i]  = a;
    st_a[i]  = s;
    wd_a[i]  = d;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    vmask       = '0;
    drive();
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    tick();
    tick();
    reset     = 1'b0;
    exp_last  = N - 1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_to    = 1'b0;
  endtask

  // Starts in an IDLE cycle; returns in the response cycle.
  task automatic xfer_run(input int waits, input logic err,
                          input logic [DW-1:0] rd, input bit rereq);
    int g;
    int c;
    bit aborted;
    logic w;
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
    drive();
    #1;
    g = rr_pick(vmask);
    chk("grant_exists", 64'(g >= 0), 64'd1);
    if (g < 0) return;
    chk("req_ready", 64'(bus.req_ready), 64'(N'(1) << g));
    w = wr_a[g];
    a = ad_a[g];
    s = w ? st_a[g] : '0;
    d = w ? wd_a[g] : '0;
    tick();
    exp_last = g;
    if (!rereq) vmask[g] = 1'b0;
    drive();
    bus.pready = 1'($urandom);
    #1;
    chk("setup_psel", 64'(bus.psel), 64'd1);
    chk("setup_penable", 64'(bus.penable), 64'd0);
    chk("setup_paddr", 64'(bus.paddr), 64'(a));
    chk("setup_pwrite", 64'(bus.pwrite), 64'(w));
    chk("setup_psrtb", 64'(bus.psrtb), 64'(s));
    chk("setup_pwdata", 64'(bus.pwdata), 64'(d));
    chk("setup_ready", 64'(bus.req_ready), 64'd0);
    chk("setup_rspv", 64'(bus.rsp_valid), 64'd0);
    chk("hold_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
    chk("hold_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("hold_to", 64'(bus.rsp_timeout), 64'(exp_to));
    tick();
    c = 0;
    aborted = 0;
    while (1) begin
      bus.pready  = (c >= waits);
      bus.pslverr = (c >= waits) ? err : 1'($urandom);
      bus.prdata  = (c >= waits) ? rd : DW'($urandom);
      #1;
      chk("acc_psel", 64'(bus.psel), 64'd1);
      chk("acc_penable", 64'(bus.penable), 64'd1);
      chk("acc_paddr", 64'(bus.paddr), 64'(a));
      chk("acc_pwdata", 64'(bus.pwdata), 64'(d));
      chk("acc_ready", 64'(bus.req_ready), 64'd0);
      tick();
      if (c >= waits) break;
      if (c == TO - 1) begin
        aborted = 1;
        break;
      end
      c++;
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    if (aborted) begin
      exp_rdata = '0;
      exp_err   = 1'b1;
      exp_to    = 1'b1;
    end else begin
      exp_rdata = w ? '0 : rd;
      exp_err   = err;
      exp_to    = 1'b0;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(N'(1) << g));
    chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
    chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
    chk("end_psel", 64'(bus.psel), 64'd0);
    chk("end_penable", 64'(bus.penable), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      wr_a[i] = 1'b0;
      ad_a[i] = '0;
      st_a[i] = '0;
      wd_a[i] = '0;
    end
    do_reset();

    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_psrtb", 64'(bus.psrtb), 64'd0);
    chk("rst_rspv", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);

    set_cmd(0, 1'b1, 12'h010, 4'hF, 32'hA5A5_0001);
    xfer_run(0, 1'b0, 32'h0, 0);

    do_reset();
    set_cmd(0, 1'b0, 12'h004, 4'h0, 32'h0);
    set_cmd(1, 1'b0, 12'h008, 4'h0, 32'h0);
    repeat (4) xfer_run(0, 1'b0, DW'($urandom), 1);
    vmask = '0;

    set_cmd(0, 1'b0, 12'h00C, 4'h0, 32'h0);
    xfer_run(3, 1'b0, 32'h1234_5678, 0);

    set_cmd(1, 1'b0, 12'h020, 4'h0, 32'h0);
    xfer_run(100, 1'b0, 32'hDEAD_BEEF, 0);

    set_cmd(2, 1'b1, 12'h030, 4'h3, 32'h0BAD_F00D);
    xfer_run(1, 1'b1, DW'($urandom), 0);

    set_cmd(0, 1'b1, 12'h040, 4'hF, 32'h1111_2222);
    drive();
    #1;
    chk("rstx_ready", 64'(bus.req_ready), 64'd1);
    tick();
    vmask = '0;
    drive();
    tick();
    bus.pready = 1'b0;
    #1;
    chk("rstx_penable", 64'(bus.penable), 64'd1);
    reset = 1'b1;
    tick();
    chk("rstx_psel", 64'(bus.psel), 64'd0);
    chk("rstx_pen", 64'(bus.penable), 64'd0);
    chk("rstx_rspv", 64'(bus.rsp_valid), 64'd0);
    reset = 1'b0;
    exp_last  = N - 1;
    exp_rdata = '0;
    exp_err   = 1'b0;
    exp_to    = 1'b0;
    tick();
    chk("rstx_rspv2", 64'(bus.rsp_valid), 64'd0);
    chk("rstx_err", 64'(bus.rsp_err), 64'd0);
    set_cmd(0, 1'b0, 12'h050, 4'h0, 32'h0);
    set_cmd(1, 1'b0, 12'h060, 4'h0, 32'h0);
    xfer_run(0, 1'b0, 32'h5555_AAAA, 0);
    vmask = '0;

    for (int it = 0; it < 40; it++) begin
      int waits;
      for (int i = 0; i < N; i++) begin
        if (!vmask[i] && ($urandom % 2 == 0))
          set_cmd(i, 1'($urandom), AW'($urandom), SW'($urandom),
                  DW'($urandom));
        else if (vmask[i] && ($urandom % 8 == 0))
          vmask[i] = 1'b0;
      end
      if (vmask == '0)
        set_cmd(int'($urandom % N), 1'($urandom), AW'($urandom),
                SW'($urandom), DW'($urandom));
      waits = ($urandom % 10 == 0) ? 20 : int'($urandom % 4);
      xfer_run(waits, 1'($urandom % 4 == 0), DW'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
